// File: rtl/stoch_pkg.sv
// stoch_pkg: shared types and width helpers for the stochastic decode blocks
package stoch_pkg;
  typedef enum logic {IDLE, ACCUM} stoch_decode_state_t;
  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/stoch_decode.sv
// stoch_decode: single-element ones counter with snapshot output register
module stoch_decode #(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc_en,
  input  logic         x,
  input  logic         snap,
  output logic [W-1:0] y
);
  logic [W-1:0] acc;
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (snap) y <= acc + W'(x);
      acc <= clr ? '0 : inc_en ? acc + W'(x) : acc;
    end
  end
endmodule

// File: rtl/stoch_decode_mat.sv
// stoch_decode_mat: windowed ones-count decoder for a matrix of unipolar bitstreams
module stoch_decode_mat
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS = 2,
  parameter int NUM_COLS = 2,
  parameter int WINDOW_LEN = 256,
  localparam int COUNT_WIDTH = count_width(WINDOW_LEN)
) (
  input  logic                                             CLK,
  input  logic                                             RST,
  input  logic                                             START,
  input  logic                                             EN,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                X,
  output logic                                             BUSY,
  output logic                                             Y_VALID,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][COUNT_WIDTH-1:0] Y
);
  localparam int CW = WINDOW_LEN > 1 ? $clog2(WINDOW_LEN) : 1;
  stoch_decode_state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic accept, last, clr;
  always_comb begin
    accept    = state == ACCUM && EN;
    last      = accept && cnt == CW'(WINDOW_LEN - 1);
    clr       = START && (state == IDLE || last);
    state_nxt = state == IDLE ? (START ? ACCUM : IDLE) : (last && !START ? IDLE : ACCUM);
  end
  // a completion cycle always rewinds cnt so it never counts past WINDOW_LEN-1
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      Y_VALID <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (clr || last) ? '0 : accept ? cnt + CW'(1) : cnt;
      Y_VALID <= last;
    end
  end
  assign BUSY = state == ACCUM;
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      stoch_decode #(.W(COUNT_WIDTH)) u_elem (
        .CLK(CLK), .RST(RST), .clr(clr), .inc_en(accept),
        .x(X[r][c]), .snap(last), .y(Y[r][c])
      );
    end
  end
endmodule

// File: tb/tb_stoch_decode_mat.sv
// tb_stoch_decode_mat: directed checks of the windowed decoder (WINDOW_LEN=8 and 1)
module tb_stoch_decode_mat;
  logic clk = 1'b0;
  logic rst, start, en, start1, en1;
  logic [1:0][1:0] x, x1;
  logic busy, y_valid, busy1, y_valid1;
  logic [1:0][1:0][3:0] y;
  logic [1:0][1:0][0:0] y1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LEN(8)) dut (
    .CLK(clk), .RST(rst), .START(start), .EN(en), .X(x),
    .BUSY(busy), .Y_VALID(y_valid), .Y(y)
  );
  stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LEN(1)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .EN(en1), .X(x1),
    .BUSY(busy1), .Y_VALID(y_valid1), .Y(y1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input int e00, input int e01, input int e10, input int e11);
    chk({tag, "_y00"}, 32'(y[0][0]), 32'(e00));
    chk({tag, "_y01"}, 32'(y[0][1]), 32'(e01));
    chk({tag, "_y10"}, 32'(y[1][0]), 32'(e10));
    chk({tag, "_y11"}, 32'(y[1][1]), 32'(e11));
  endtask

  // steps until Y_VALID, bounded; n is the number of edges taken
  task automatic run_until_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!y_valid && n < 40);
  endtask

  initial begin
    int n;
    logic early, dropped;
    logic [3:0] pats [4];
    pats = '{4'b0101, 4'b1010, 4'b1111, 4'b0000};
    rst = 1'b1; start = 1'b0; en = 1'b1; x = '0;
    start1 = 1'b0; en1 = 1'b1; x1 = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(y_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_busy1", 32'(busy1), 0);
    rst = 1'b0;

    // constant streams
    x = 4'b0101; start = 1'b1;
    step();
    chk("s1_busy_after_start", 32'(busy), 1);
    start = 1'b0;
    run_until_valid(n);
    chk("s1_latency", 32'(n + 1), 9);
    chk("s1_busy_drop", 32'(busy), 0);
    chk_y("s1", 8, 0, 8, 0);
    step();
    chk("s1_valid_single", 32'(y_valid), 0);

    // patterned stream with a 3-cycle stall at X=all ones
    start = 1'b1; x = 4'b0000;
    step();
    start = 1'b0;
    early = 1'b0;
    for (int s = 0; s < 8; s++) begin
      if (s == 4) begin
        en = 1'b0; x = 4'b1111;
        for (int k = 0; k < 3; k++) begin
          step();
          early |= y_valid;
        end
        en = 1'b1;
      end
      x = {3'b000, s % 2 == 0};
      step();
      if (s < 7) early |= y_valid;
    end
    chk("s2_no_early_valid", 32'(early), 0);
    chk("s2_valid_delayed", 32'(y_valid), 1);
    chk_y("s2", 4, 0, 0, 0);

    // reset at cnt=5
    x = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 5; s++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s4_busy", 32'(busy), 0);
    chk("s4_valid", 32'(y_valid), 0);
    chk("s4_y", 32'(y), 0);
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      early |= y_valid;
    end
    chk("s4_no_valid", 32'(early), 0);
    x = 4'b1001; start = 1'b1;
    step();
    start = 1'b0;
    run_until_valid(n);
    chk("s4_restart_latency", 32'(n + 1), 9);
    chk_y("s4", 8, 0, 0, 8);

    // back-to-back windows
    x = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 7; s++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s3_valid1", 32'(y_valid), 1);
    chk("s3_busy_kept", 32'(busy), 1);
    chk_y("s3w1", 8, 8, 8, 8);
    x = 4'b0000;
    dropped = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (!y_valid) dropped |= !busy;
    end while (!y_valid && n < 40);
    chk("s3_busy_never_drops", 32'(dropped), 0);
    chk("s3_spacing", 32'(n), 8);
    chk_y("s3w2", 0, 0, 0, 0);
    chk("s3_busy_end", 32'(busy), 0);

    // START mid-window at cnt=3 is ignored
    x = 4'b0010; start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 3; s++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!y_valid && n < 40);
    chk("s5_latency", 32'(n + 5), 9);
    chk_y("s5", 0, 8, 0, 0);

    // WINDOW_LEN=1: every accepted sample completes a window
    start1 = 1'b1;
    step();
    chk("s6_busy1", 32'(busy1), 1);
    for (int k = 0; k < 4; k++) begin
      x1 = pats[k];
      step();
      chk("s6_valid1", 32'(y_valid1), 1);
      chk("s6_y1", 32'(y1), 32'(pats[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
